// File: rtl/rt_ibex_window_pkg.sv
// Shared types and constants for the register-window sequencer.
//   window_ctrl_state_e   : sequencer FSM state encoding
//   depth_w()             : counter width needed to hold n_states distinct values
//   MAX_WINDOWS_SUPPORTED : largest register-window count the register file supports
package rt_ibex_window_pkg;

    localparam int unsigned MAX_WINDOWS_SUPPORTED = 16;
    localparam int unsigned STATS_DEPTH_W         = 8;
    localparam int unsigned STATS_OVF_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_INC,
        ST_DEC,
        ST_RESTORE
    } window_ctrl_state_e;

    // Width of a counter that must represent n_states values (0 .. n_states-1), min 1 bit.
    function automatic int unsigned depth_w(input int unsigned n_states);
        return (n_states <= 2) ? 1 : $clog2(n_states);
    endfunction

endpackage

// File: rtl/rt_ibex_window_depth_cnt.sv
// Saturating up/down depth counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_inc, i_dec  : count up / down (both at once cancel out)
//   o_cnt         : current count, 0 .. MAX
//   o_ovf, o_udf  : combinational flags, request to step past MAX / below 0 (count holds)
module rt_ibex_window_depth_cnt #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned MAX   = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_ovf,
    output logic             o_udf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;

    assign o_ovf = i_inc && !i_dec && (r_cnt == MAX_V);
    assign o_udf = i_dec && !i_inc && (r_cnt == '0);
    assign o_cnt = r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && !o_ovf) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc && !o_udf) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/rt_ibex_window_ctrl.sv
// Register-window sequencer for interrupt entry / mret.
// Orders CSR save/restore against window-pointer moves, tracks hardware and
// software nesting depth, and acks every controller request with a 1-cycle pulse.
//   entry_req_i / exit_req_i   : held requests from the core controller
//   entry_ack_o / exit_ack_o   : completion pulses
//   sw_save_o / sw_restore_o   : qualify the acks: software stacks/unstacks context
//   window_full_i              : register file reports last window in use
//   save_csr_o, restore_csr_o, increment_ptr_o, decrement_ptr_o : register-file strobes
//   busy_o                     : sequence in flight
//   hw_depth_o                 : hardware nesting depth
//   err_o                      : mret at depth 0, software-depth overflow, or full-flag mismatch
// Optional build macro RT_IBEX_WINDOW_STATS_EN adds max_depth_o / overflow_cnt_o.
module rt_ibex_window_ctrl
    import rt_ibex_window_pkg::*;
#(
    parameter int unsigned NumRegisterWindows = 4,
    parameter int unsigned MaxSwDepth         = 15
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      entry_req_i,
    input  logic                                      exit_req_i,
    output logic                                      entry_ack_o,
    output logic                                      exit_ack_o,
    output logic                                      sw_save_o,
    output logic                                      sw_restore_o,
    input  logic                                      window_full_i,
    output logic                                      save_csr_o,
    output logic                                      restore_csr_o,
    output logic                                      increment_ptr_o,
    output logic                                      decrement_ptr_o,
    output logic                                      busy_o,
    output logic [depth_w(NumRegisterWindows)-1:0]    hw_depth_o,
    output logic                                      err_o
`ifdef RT_IBEX_WINDOW_STATS_EN
    ,
    output logic [STATS_DEPTH_W-1:0]                  max_depth_o,
    output logic [STATS_OVF_W-1:0]                    overflow_cnt_o
`endif
);

    localparam int unsigned HW_W = depth_w(NumRegisterWindows);
    localparam int unsigned SW_W = depth_w(MaxSwDepth + 1);
    localparam logic [HW_W-1:0] HW_LAST = HW_W'(NumRegisterWindows - 1);

    window_ctrl_state_e r_state;
    logic r_save, r_inc, r_dec, r_restore;
    logic r_entry_ack, r_exit_ack, r_sw_save, r_sw_restore, r_err;

    logic [HW_W-1:0] w_hw_depth;
    logic [SW_W-1:0] w_sw_depth;
    logic w_hw_ovf, w_hw_udf, w_sw_ovf, w_sw_udf;
    logic w_take, w_sw_entry_path, w_full_mismatch;
    logic w_hw_inc, w_hw_dec, w_sw_inc, w_sw_dec;

    // A request is still asserted in the cycle its ack is visible; skipping that
    // cycle keeps an IDLE-resolved (software/invalid) request from being taken twice.
    assign w_take = (r_state == ST_IDLE) && !(r_entry_ack || r_exit_ack);

    // Any outstanding software depth, or no hardware window left, forces software entry.
    assign w_sw_entry_path = window_full_i || (w_sw_depth != '0) || (w_hw_depth == HW_LAST);
    assign w_full_mismatch = window_full_i != (w_hw_depth == HW_LAST);

    // Depth moves on the edge that raises the corresponding ack, so hw_depth_o
    // already shows the new depth while the ack is visible.
    assign w_hw_inc = (r_state == ST_SAVE);
    assign w_hw_dec = (r_state == ST_DEC);
    assign w_sw_inc = w_take && entry_req_i && w_sw_entry_path;
    assign w_sw_dec = w_take && !entry_req_i && exit_req_i && (w_sw_depth != '0);

    rt_ibex_window_depth_cnt #(.WIDTH(HW_W), .MAX(NumRegisterWindows - 1)) u_hw_depth (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_inc  (w_hw_inc),
        .i_dec  (w_hw_dec),
        .o_cnt  (w_hw_depth),
        .o_ovf  (w_hw_ovf),
        .o_udf  (w_hw_udf)
    );

    rt_ibex_window_depth_cnt #(.WIDTH(SW_W), .MAX(MaxSwDepth)) u_sw_depth (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_inc  (w_sw_inc),
        .i_dec  (w_sw_dec),
        .o_cnt  (w_sw_depth),
        .o_ovf  (w_sw_ovf),
        .o_udf  (w_sw_udf)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_save       <= 1'b0;
            r_inc        <= 1'b0;
            r_dec        <= 1'b0;
            r_restore    <= 1'b0;
            r_entry_ack  <= 1'b0;
            r_exit_ack   <= 1'b0;
            r_sw_save    <= 1'b0;
            r_sw_restore <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_save       <= 1'b0;
            r_inc        <= 1'b0;
            r_dec        <= 1'b0;
            r_restore    <= 1'b0;
            r_entry_ack  <= 1'b0;
            r_exit_ack   <= 1'b0;
            r_sw_save    <= 1'b0;
            r_sw_restore <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_err <= w_full_mismatch;
                    if (w_take && entry_req_i) begin
                        if (w_sw_entry_path) begin
                            r_entry_ack <= 1'b1;
                            r_sw_save   <= 1'b1;
                            if (w_sw_ovf) r_err <= 1'b1;
                        end else begin
                            r_state <= ST_SAVE;
                            r_save  <= 1'b1;
                        end
                    end else if (w_take && exit_req_i) begin
                        if (w_sw_depth != '0) begin
                            r_exit_ack   <= 1'b1;
                            r_sw_restore <= 1'b1;
                        end else if (w_hw_depth != '0) begin
                            r_state <= ST_DEC;
                            r_dec   <= 1'b1;
                        end else begin
                            r_exit_ack <= 1'b1;
                            r_err      <= 1'b1;
                        end
                    end
                end
                ST_SAVE: begin
                    r_state     <= ST_INC;
                    r_inc       <= 1'b1;
                    r_entry_ack <= 1'b1;
                end
                ST_DEC: begin
                    r_state    <= ST_RESTORE;
                    r_restore  <= 1'b1;
                    r_exit_ack <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
            // Counter guards should never trip; surface it if they do.
            if (w_hw_ovf || w_hw_udf || w_sw_udf) r_err <= 1'b1;
        end
    end

    assign save_csr_o      = r_save;
    assign increment_ptr_o = r_inc;
    assign decrement_ptr_o = r_dec;
    assign restore_csr_o   = r_restore;
    assign entry_ack_o     = r_entry_ack;
    assign exit_ack_o      = r_exit_ack;
    assign sw_save_o       = r_sw_save;
    assign sw_restore_o    = r_sw_restore;
    assign err_o           = r_err;
    assign busy_o          = (r_state != ST_IDLE);
    assign hw_depth_o      = w_hw_depth;

`ifdef RT_IBEX_WINDOW_STATS_EN
    logic [STATS_DEPTH_W-1:0] r_max_depth, w_depth_sum;
    logic [STATS_OVF_W-1:0]   r_ovf_cnt;

    assign w_depth_sum = STATS_DEPTH_W'(w_hw_depth) + STATS_DEPTH_W'(w_sw_depth);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_max_depth <= '0;
            r_ovf_cnt   <= '0;
        end else begin
            if (w_depth_sum > r_max_depth) r_max_depth <= w_depth_sum;
            if (w_sw_inc && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign max_depth_o    = r_max_depth;
    assign overflow_cnt_o = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_rt_ibex_window_ctrl.sv
// Directed bench for rt_ibex_window_ctrl. Strobes are checked as one packed
// vector per cycle so any stray or missing strobe shows up in the same compare.
// A small pointer model stands in for the register file to drive window_full_i.
module tb_rt_ibex_window_ctrl;

    localparam int NW  = 4;
    localparam int MSW = 15;

    localparam int EACK = 512;
    localparam int XACK = 256;
    localparam int SWS  = 128;
    localparam int SWR  = 64;
    localparam int SAV  = 32;
    localparam int RST  = 16;
    localparam int INC  = 8;
    localparam int DEC  = 4;
    localparam int BSY  = 2;
    localparam int ERR  = 1;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       entry_req_i = 1'b0;
    logic       exit_req_i = 1'b0;
    logic       window_full_i;
    logic       entry_ack_o, exit_ack_o, sw_save_o, sw_restore_o;
    logic       save_csr_o, restore_csr_o, increment_ptr_o, decrement_ptr_o;
    logic       busy_o, err_o;
    logic [1:0] hw_depth_o;
`ifdef RT_IBEX_WINDOW_STATS_EN
    logic [7:0]  max_depth_o;
    logic [15:0] overflow_cnt_o;
`endif

    int n_tot = 0;
    int n_bad = 0;
    int ptr;

    logic [9:0] w_strb;
    assign w_strb = {entry_ack_o, exit_ack_o, sw_save_o, sw_restore_o, save_csr_o,
                     restore_csr_o, increment_ptr_o, decrement_ptr_o, busy_o, err_o};

    rt_ibex_window_ctrl #(.NumRegisterWindows(NW), .MaxSwDepth(MSW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .entry_req_i     (entry_req_i),
        .exit_req_i      (exit_req_i),
        .entry_ack_o     (entry_ack_o),
        .exit_ack_o      (exit_ack_o),
        .sw_save_o       (sw_save_o),
        .sw_restore_o    (sw_restore_o),
        .window_full_i   (window_full_i),
        .save_csr_o      (save_csr_o),
        .restore_csr_o   (restore_csr_o),
        .increment_ptr_o (increment_ptr_o),
        .decrement_ptr_o (decrement_ptr_o),
        .busy_o          (busy_o),
        .hw_depth_o      (hw_depth_o),
        .err_o           (err_o)
`ifdef RT_IBEX_WINDOW_STATS_EN
        ,
        .max_depth_o     (max_depth_o),
        .overflow_cnt_o  (overflow_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Register-file window pointer, reset by the same rst_ni.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)              ptr <= 0;
        else if (increment_ptr_o) ptr <= ptr + 1;
        else if (decrement_ptr_o) ptr <= ptr - 1;
    end
    assign window_full_i = (ptr == NW - 1);

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic hw_entry(input int d);
        @(negedge clk_i); chk("hent_idle", 32'(w_strb), 0); entry_req_i = 1'b1;
        @(negedge clk_i); chk("hent_save", 32'(w_strb), SAV | BSY);
        @(negedge clk_i); chk("hent_inc", 32'(w_strb), INC | EACK | BSY);
        chk("hent_depth", 32'(hw_depth_o), d); entry_req_i = 1'b0;
        @(negedge clk_i); chk("hent_done", 32'(w_strb), 0);
    endtask

    task automatic hw_exit(input int d);
        @(negedge clk_i); chk("hext_idle", 32'(w_strb), 0); exit_req_i = 1'b1;
        @(negedge clk_i); chk("hext_dec", 32'(w_strb), DEC | BSY);
        @(negedge clk_i); chk("hext_rest", 32'(w_strb), RST | XACK | BSY);
        chk("hext_depth", 32'(hw_depth_o), d); exit_req_i = 1'b0;
        @(negedge clk_i); chk("hext_done", 32'(w_strb), 0);
    endtask

    task automatic sw_entry(input int e);
        @(negedge clk_i); chk("sent_idle", 32'(w_strb), 0); entry_req_i = 1'b1;
        @(negedge clk_i); chk("sent_ack", 32'(w_strb), EACK | SWS | (e != 0 ? ERR : 0));
        chk("sent_depth", 32'(hw_depth_o), NW - 1); entry_req_i = 1'b0;
        @(negedge clk_i); chk("sent_done", 32'(w_strb), 0);
    endtask

    task automatic sw_exit();
        @(negedge clk_i); chk("sext_idle", 32'(w_strb), 0); exit_req_i = 1'b1;
        @(negedge clk_i); chk("sext_ack", 32'(w_strb), XACK | SWR);
        exit_req_i = 1'b0;
        @(negedge clk_i); chk("sext_done", 32'(w_strb), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_strb", 32'(w_strb), 0);
        chk("rst_depth", 32'(hw_depth_o), 0);
        rst_ni = 1'b1;

        // Single entry / exit
        hw_entry(1);
        hw_exit(0);

        // Nest to full, one software level, unwind
        hw_entry(1); hw_entry(2); hw_entry(3);
        sw_entry(0);
        sw_exit();
        hw_exit(2); hw_exit(1); hw_exit(0);

        // Simultaneous requests at depth 1: entry first, then exit
        hw_entry(1);
        @(negedge clk_i); chk("sim_idle", 32'(w_strb), 0);
        entry_req_i = 1'b1; exit_req_i = 1'b1;
        @(negedge clk_i); chk("sim_save", 32'(w_strb), SAV | BSY);
        @(negedge clk_i); chk("sim_inc", 32'(w_strb), INC | EACK | BSY);
        chk("sim_depth2", 32'(hw_depth_o), 2); entry_req_i = 1'b0;
        @(negedge clk_i); chk("sim_gap", 32'(w_strb), 0);
        @(negedge clk_i); chk("sim_dec", 32'(w_strb), DEC | BSY);
        @(negedge clk_i); chk("sim_rest", 32'(w_strb), RST | XACK | BSY);
        chk("sim_depth1", 32'(hw_depth_o), 1); exit_req_i = 1'b0;
        @(negedge clk_i); chk("sim_done", 32'(w_strb), 0);
        hw_exit(0);

        // mret at depth 0
        @(negedge clk_i); exit_req_i = 1'b1;
        @(negedge clk_i); chk("bad_mret", 32'(w_strb), XACK | ERR);
        chk("bad_depth", 32'(hw_depth_o), 0); exit_req_i = 1'b0;
        @(negedge clk_i); chk("bad_done", 32'(w_strb), 0);
        hw_entry(1);
        hw_exit(0);

        // Reset during SAVE
        hw_entry(1);
        @(negedge clk_i); entry_req_i = 1'b1;
        @(negedge clk_i); chk("mid_save", 32'(w_strb), SAV | BSY);
        rst_ni = 1'b0;
        #1 chk("mid_rst_strb", 32'(w_strb), 0);
        chk("mid_rst_depth", 32'(hw_depth_o), 0);
        entry_req_i = 1'b0;
        @(negedge clk_i); chk("mid_rst_hold", 32'(w_strb), 0);
        rst_ni = 1'b1;
        hw_entry(1);
        hw_exit(0);

`ifdef RT_IBEX_WINDOW_STATS_EN
        // High-water mark and software-entry count (counters cleared by the reset above)
        chk("st_max0", 32'(max_depth_o), 0);
        hw_entry(1); hw_entry(2); hw_entry(3);
        sw_entry(0); sw_entry(0);
        chk("st_max", 32'(max_depth_o), 5);
        chk("st_cnt", 32'(overflow_cnt_o), 2);
        sw_exit(); sw_exit();
        hw_exit(2); hw_exit(1); hw_exit(0);
        chk("st_max_hold", 32'(max_depth_o), 5);
        chk("st_cnt_hold", 32'(overflow_cnt_o), 2);
`endif

        // Software depth saturation: 15 clean levels, 16th flags err and saturates,
        // so exactly 15 software exits before the hardware path resumes.
        hw_entry(1); hw_entry(2); hw_entry(3);
        for (int i = 0; i < MSW; i++) sw_entry(0);
        sw_entry(1);
        for (int i = 0; i < MSW; i++) sw_exit();
        hw_exit(2); hw_exit(1); hw_exit(0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
